// File: rtl/spi_txn_pkg.sv
// spi_txn_pkg: state encoding, frame size and timing defaults shared by the SPI transaction controller
package spi_txn_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, BIT_LO, BIT_HI, GAP, HOLD, DONE} state_e;
  localparam int NBYTES = 3;
  localparam int DEF_CLK_DIV = 5;
  localparam int DEF_CS_SETUP = 10;
  localparam int DEF_GAP_CYC = 50;
  localparam int DEF_CS_HOLD = 50;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/spi_byte_shift.sv
// spi_byte_shift: clocks one byte out MSB first on SCK/MOSI and shifts MISO in at the end of each SCK high phase
module spi_byte_shift
  import spi_txn_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic [7:0] rx_o,
  output logic       done_o
);
  localparam int DW = $clog2(CLK_DIV + 1);
  state_e ph_q;
  logic [DW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] tx_q, rx_q;
  logic sck_q, mosi_q, last;
  assign last = cnt_q == '0;
  assign done_o = ph_q == BIT_HI && last && bit_q == '0;
  assign sck_o = sck_q;
  assign mosi_o = mosi_q;
  assign rx_o = rx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      if (ph_q == BIT_HI && last) rx_q <= {rx_q[6:0], miso_i};
      // start wins over the final high phase so back-to-back bytes need no idle cycle
      if (start_i) begin
        ph_q <= BIT_LO;
        cnt_q <= DW'(CLK_DIV - 1);
        bit_q <= 3'd7;
        tx_q <= {tx_i[6:0], 1'b0};
        mosi_q <= tx_i[7];
        sck_q <= 1'b0;
      end else if (ph_q == BIT_LO) begin
        if (last) begin
          ph_q <= BIT_HI;
          sck_q <= 1'b1;
          cnt_q <= DW'(CLK_DIV - 1);
        end else cnt_q <= cnt_q - DW'(1);
      end else if (ph_q == BIT_HI) begin
        if (!last) cnt_q <= cnt_q - DW'(1);
        else if (bit_q == '0) begin
          ph_q <= IDLE;
          sck_q <= 1'b0;
        end else begin
          ph_q <= BIT_LO;
          sck_q <= 1'b0;
          bit_q <= bit_q - 3'd1;
          mosi_q <= tx_q[7];
          tx_q <= {tx_q[6:0], 1'b0};
          cnt_q <= DW'(CLK_DIV - 1);
        end
      end
    end
  end
endmodule

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: frames a cmd/addr/wdata request as a 3-byte SPI mode-0 transaction and returns the last MISO byte
module spi_txn_ctrl
  import spi_txn_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int CS_HOLD  = DEF_CS_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  localparam int CW = $clog2(max4(CLK_DIV, CS_SETUP, GAP_CYC, CS_HOLD) + 1);
  state_e st_q;
  logic [CW-1:0] cnt_q;
  logic [1:0] byte_q;
  logic [23:0] data_q;
  logic ready_q, busy_q, cs_q, rsp_valid_q;
  logic [7:0] rsp_rdata_q, tx, rx;
  logic start, byte_done;
  // byte_q indexes the next byte to launch, so NBYTES means the last byte is in flight
  assign tx = byte_q == 2'd0 ? data_q[23:16] : byte_q == 2'd1 ? data_q[15:8] : data_q[7:0];
  assign start = ((st_q == SETUP || st_q == GAP) && cnt_q == '0)
              || (st_q == BIT_LO && byte_done && byte_q != 2'(NBYTES) && GAP_CYC == 0);
  assign req_ready = ready_q;
  assign busy = busy_q;
  assign spi_cs = cs_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .tx_i(tx),
    .miso_i(spi_miso),
    .sck_o(spi_sck),
    .mosi_o(spi_mosi),
    .rx_o(rx),
    .done_o(byte_done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      cs_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (start) byte_q <= byte_q + 2'd1;
      case (st_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            data_q <= {req_cmd, req_addr, req_wdata};
            ready_q <= 1'b0;
            busy_q <= 1'b1;
            cs_q <= 1'b0;
            byte_q <= '0;
            cnt_q <= CW'(CS_SETUP - 1);
            st_q <= SETUP;
          end
        end
        SETUP, GAP: if (cnt_q == '0) st_q <= BIT_LO; else cnt_q <= cnt_q - CW'(1);
        BIT_LO: if (byte_done) begin
          if (byte_q == 2'(NBYTES)) begin
            st_q <= HOLD;
            cnt_q <= CW'(CS_HOLD - 1);
          end else if (GAP_CYC > 0) begin
            st_q <= GAP;
            cnt_q <= CW'(GAP_CYC - 1);
          end
        end
        HOLD: if (cnt_q == '0) begin
          st_q <= DONE;
          cs_q <= 1'b1;
          busy_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rx;
        end else cnt_q <= cnt_q - CW'(1);
        default: begin
          st_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
